// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and the instruction-memory request/valid handshake.
// Registers {inst, pc} toward decode; a one-entry skid holds responses during stall.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h1000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_sel,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid
);

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      DRAIN
   } state_e;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } fetch_t;

   state_e      state_q;
   logic [31:0] pc_q;
   logic        req_q;
   fetch_t      out_q;
   logic        out_v_q;
   fetch_t      skid_q;
   logic        skid_v_q;

   logic [31:0] tgt;
   logic [31:0] pc_inc;
   logic        rsp;
   logic        unused;

   assign tgt    = {redirect_pc[31:2], 2'b00};
   assign pc_inc = pc_q + 32'd4;
   assign unused = ^redirect_pc[1:0];

   // req_q is high exactly while a request is outstanding in FETCH
   assign rsp = req_q & imem_valid;

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign inst       = out_q.word;
   assign inst_pc    = out_q.pc;
   assign inst_valid = out_v_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         req_q    <= 1'b0;
         out_q    <= '{word: NOP, pc: 32'h0};
         out_v_q  <= 1'b0;
         skid_q   <= '0;
         skid_v_q <= 1'b0;
      end else begin
         unique case (state_q)
            BOOT: begin
               if (pc_sel) pc_q <= tgt;
               state_q <= FETCH;
               req_q   <= 1'b1;
            end
            FETCH: begin
               if (pc_sel) begin
                  pc_q       <= tgt;
                  out_q.word <= NOP;
                  out_v_q    <= 1'b0;
                  skid_v_q   <= 1'b0;
                  if (req_q && !imem_valid) begin
                     state_q <= DRAIN;
                     req_q   <= 1'b0;
                  end else begin
                     req_q <= 1'b1;
                  end
               end else if (rsp) begin
                  pc_q <= pc_inc;
                  if (stall) begin
                     skid_q   <= '{word: imem_rdata, pc: pc_q};
                     skid_v_q <= 1'b1;
                     req_q    <= 1'b0;
                  end else begin
                     out_q   <= '{word: imem_rdata, pc: pc_q};
                     out_v_q <= 1'b1;
                  end
               end else if (!stall) begin
                  if (skid_v_q) begin
                     out_q    <= skid_q;
                     out_v_q  <= 1'b1;
                     skid_v_q <= 1'b0;
                     req_q    <= 1'b1;
                  end else begin
                     out_q.word <= NOP;
                     out_v_q    <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (pc_sel) pc_q <= tgt;
               if (imem_valid) begin
                  state_q <= FETCH;
                  req_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= BOOT;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule
